tlb_op_sequencer: RTL and testbench

- Sequences the four MIPS TLB instructions (TLBP, TLBR, TLBWI, TLBWR) between the pipeline, the 8-entry TLB array and CP0.
- Locks the TLB array away from instruction/data translation for the whole operation.
- Issues the array access, then commits probe/read results into CP0 with one-cycle tlbp/tlbr strobes.
- Sits beside CP0 in the memory stage; the pipeline stalls on !op_ready.

---
 rtl/tlb_pkg.sv | 39 +++
 rtl/tlb_hitvec_encode.sv | 34 +++
 rtl/tlb_op_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_tlb_op_sequencer.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_pkg.sv
// -----------------------------------------------------------------------------
// tlb_pkg
// Shared types and constants for the TLB instruction sequencer.
//   TLB_ENTRIES / IDX_W / CONF_W : array geometry and packed-entry width
//   tlb_op_e                     : TLBP / TLBR / TLBWI / TLBWR op codes
//   seq_state_e                  : sequencer FSM states
//   VPN2_* / G_BIT / ASID_*      : field positions inside a packed entry
// -----------------------------------------------------------------------------
package tlb_pkg;

   localparam int TLB_ENTRIES = 8;
   localparam int IDX_W       = 3;
   localparam int CONF_W      = 86;

   // Packed entry: {VPN2[18:0], G, ASID[7:0], EntryLo0[28:0], EntryLo1[28:0]}
   localparam int VPN2_HI = 85;
   localparam int VPN2_LO = 67;
   localparam int G_BIT   = 66;
   localparam int ASID_HI = 65;
   localparam int ASID_LO = 58;
   localparam int VPN2_W  = VPN2_HI - VPN2_LO + 1;
   localparam int ASID_W  = ASID_HI - ASID_LO + 1;

   typedef enum logic [1:0] {
      OP_TLBP  = 2'b00,
      OP_TLBR  = 2'b01,
      OP_TLBWI = 2'b10,
      OP_TLBWR = 2'b11
   } tlb_op_e;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DRAIN  = 3'd1,
      S_ISSUE  = 3'd2,
      S_WAIT   = 3'd3,
      S_COMMIT = 3'd4
   } seq_state_e;

endpackage

// File: rtl/tlb_hitvec_encode.sv
// -----------------------------------------------------------------------------
// tlb_hitvec_encode
// Turns the per-entry probe match vector into a hit flag, the index of the
// lowest matching entry and a multi-hit flag. Only compiled when
// TLB_PROBE_MULTIHIT_EN is defined; the default build has no use for it.
// Ports:
//   vec   in  TLB_ENTRIES  one bit per entry that matched the probe
//   hit   out 1            at least one entry matched
//   index out IDX_W        lowest matching entry (0 when none)
//   multi out 1            two or more entries matched
// -----------------------------------------------------------------------------
`ifdef TLB_PROBE_MULTIHIT_EN
module tlb_hitvec_encode
   import tlb_pkg::*;
(
   input  logic [TLB_ENTRIES-1:0] vec,
   output logic                   hit,
   output logic [IDX_W-1:0]       index,
   output logic                   multi
);

   always_comb begin
      hit   = |vec;
      index = '0;
      // Scan downwards so the lowest set bit is the last one written.
      for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
         if (vec[i]) index = IDX_W'(i);
      end
      // Clearing the lowest set bit leaves something only on a multi-hit.
      multi = (vec & (vec - TLB_ENTRIES'(1))) != '0;
   end

endmodule
`endif

// File: rtl/tlb_op_sequencer.sv
// -----------------------------------------------------------------------------
// tlb_op_sequencer
// Runs one MIPS TLB instruction (TLBP/TLBR/TLBWI/TLBWR) at a time between the
// pipeline, the 8-entry TLB array and CP0. The array is locked away from
// translation lookups from acceptance until the op retires.
//   IDLE -> DRAIN (wait for in-flight lookup) -> ISSUE (array access)
//        -> WAIT (capture result) -> COMMIT (CP0 strobe, op_done) -> IDLE
// Optional feature macro: TLB_PROBE_MULTIHIT_EN
//   replaces tlb_probe_hit/tlb_probe_index with tlb_probe_hit_vec and adds the
//   mcheck pulse for multiple matching entries.
// Ports:
//   clk, rst                       clock, async active-low reset
//   op_valid/op_code/op_ready      pipeline handshake, op_done retire pulse
//   flush                          aborts an op still in DRAIN
//   cp0_index/cp0_random           target index sources
//   cp0_tlb_conf_out               entry image from CP0 (write data / probe key)
//   cp0_tlbp/cp0_tlbr              CP0 commit strobes
//   miss_probe/matched_index_probe probe result, held after commit
//   cp0_tlb_conf_in                read result, held after commit
//   lookup_busy/tlb_lock           translation interlock
//   tlb_we/tlb_re/tlb_addr/tlb_wdata/tlb_rdata  array access
//   tlb_probe_req/_vpn2/_asid/_hit/_index       array probe
// -----------------------------------------------------------------------------
module tlb_op_sequencer
   import tlb_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   op_valid,
   input  logic [1:0]             op_code,
   output logic                   op_ready,
   output logic                   op_done,
   input  logic                   flush,
   input  logic [IDX_W-1:0]       cp0_index,
   input  logic [IDX_W-1:0]       cp0_random,
   input  logic [CONF_W-1:0]      cp0_tlb_conf_out,
   output logic                   cp0_tlbp,
   output logic                   cp0_tlbr,
   output logic                   miss_probe,
   output logic [IDX_W-1:0]       matched_index_probe,
   output logic [CONF_W-1:0]      cp0_tlb_conf_in,
   input  logic                   lookup_busy,
   output logic                   tlb_lock,
   output logic                   tlb_we,
   output logic                   tlb_re,
   output logic [IDX_W-1:0]       tlb_addr,
   output logic [CONF_W-1:0]      tlb_wdata,
   input  logic [CONF_W-1:0]      tlb_rdata,
`ifdef TLB_PROBE_MULTIHIT_EN
   input  logic [TLB_ENTRIES-1:0] tlb_probe_hit_vec,
   output logic                   mcheck,
`else
   input  logic                   tlb_probe_hit,
   input  logic [IDX_W-1:0]       tlb_probe_index,
`endif
   output logic                   tlb_probe_req,
   output logic [VPN2_W-1:0]      tlb_probe_vpn2,
   output logic [ASID_W-1:0]      tlb_probe_asid
);

   seq_state_e          state, state_nxt;
   tlb_op_e             op_q;
   logic [IDX_W-1:0]    idx_q;
   logic [CONF_W-1:0]   conf_q;
   logic                run_q;
   logic                accept;
   logic                probe_hit;
   logic [IDX_W-1:0]    probe_idx;

   // ---------------------------------------------------------------- probe result
`ifdef TLB_PROBE_MULTIHIT_EN
   logic probe_multi;
   logic mcheck_q;

   tlb_hitvec_encode u_hitvec_encode (
      .vec   (tlb_probe_hit_vec),
      .hit   (probe_hit),
      .index (probe_idx),
      .multi (probe_multi)
   );
`else
   assign probe_hit = tlb_probe_hit;
   assign probe_idx = tlb_probe_index;
`endif

   // ---------------------------------------------------------------- handshake
   // run_q keeps op_ready low while rst is asserted and until the first edge
   // after release, so nothing is accepted straight out of reset.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state always uses non-blocking assignment so every
      // register samples the pre-edge values of its inputs.
      if (!rst) run_q <= 1'b0;
      else      run_q <= 1'b1;
   end

   assign op_ready = run_q && (state == S_IDLE) && !flush;
   assign accept   = op_valid && op_ready;

   // ---------------------------------------------------------------- operand latch
   // NOTE: these are plain flops, not a memory, so they are reset along with
   // the state; the array itself lives outside this block.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_q   <= OP_TLBP;
         idx_q  <= '0;
         conf_q <= '0;
      end else if (accept) begin
         op_q   <= tlb_op_e'(op_code);
         idx_q  <= (tlb_op_e'(op_code) == OP_TLBWR) ? cp0_random : cp0_index;
         conf_q <= cp0_tlb_conf_out;
      end
   end

   assign tlb_addr       = idx_q;
   assign tlb_wdata      = conf_q;
   assign tlb_probe_vpn2 = conf_q[VPN2_HI:VPN2_LO];
   assign tlb_probe_asid = conf_q[ASID_HI:ASID_LO];

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      // NOTE: every output of this block gets a default first; a path that
      // skipped an assignment would otherwise infer a latch.
      state_nxt     = state;
      tlb_lock      = 1'b0;
      tlb_we        = 1'b0;
      tlb_re        = 1'b0;
      tlb_probe_req = 1'b0;
      op_done       = 1'b0;
      cp0_tlbp      = 1'b0;
      cp0_tlbr      = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (accept) state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            tlb_lock = 1'b1;
            // Flush wins over a drained array: nothing has touched it yet.
            if (flush)             state_nxt = S_IDLE;
            else if (!lookup_busy) state_nxt = S_ISSUE;
         end
         S_ISSUE: begin
            tlb_lock      = 1'b1;
            tlb_we        = (op_q == OP_TLBWI) || (op_q == OP_TLBWR);
            tlb_re        = (op_q == OP_TLBR);
            tlb_probe_req = (op_q == OP_TLBP);
            state_nxt     = S_WAIT;
         end
         S_WAIT: begin
            tlb_lock  = 1'b1;
            state_nxt = S_COMMIT;
         end
         S_COMMIT: begin
            tlb_lock  = 1'b1;
            op_done   = 1'b1;
            cp0_tlbp  = (op_q == OP_TLBP);
            cp0_tlbr  = (op_q == OP_TLBR);
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- results
   // Array results are valid in WAIT; registering them there presents them
   // in COMMIT alongside the strobes, and they hold until the next op of the
   // same kind overwrites them.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         miss_probe          <= 1'b0;
         matched_index_probe <= '0;
         cp0_tlb_conf_in     <= '0;
      end else if (state == S_WAIT) begin
         if (op_q == OP_TLBP) begin
            miss_probe          <= !probe_hit;
            matched_index_probe <= probe_hit ? probe_idx : '0;
         end
         if (op_q == OP_TLBR) cp0_tlb_conf_in <= tlb_rdata;
      end
   end

`ifdef TLB_PROBE_MULTIHIT_EN
   // Cleared for non-probe ops so a stale multi-hit never leaks into COMMIT.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                 mcheck_q <= 1'b0;
      else if (state == S_WAIT) mcheck_q <= (op_q == OP_TLBP) && probe_multi;
   end

   assign mcheck = mcheck_q && (state == S_COMMIT);
`endif

endmodule

// File: tb/tb_tlb_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_tlb_op_sequencer
// Self-checking bench for tlb_op_sequencer. A cycle-level reference model
// (op in flight, the cycle its array access happens, captured results) is
// compared against the DUT on every falling edge; directed scenarios add
// literal expectations, then a long randomized phase follows.
// Builds with or without TLB_PROBE_MULTIHIT_EN.
// -----------------------------------------------------------------------------
module tb_tlb_op_sequencer;
   import tlb_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic op_valid, flush, lookup_busy;
   logic [1:0] op_code;
   logic [2:0] cp0_index, cp0_random;
   logic [85:0] cp0_tlb_conf_out, tlb_rdata;
   logic op_ready, op_done, cp0_tlbp, cp0_tlbr, miss_probe;
   logic [2:0] matched_index_probe, tlb_addr;
   logic [85:0] cp0_tlb_conf_in, tlb_wdata;
   logic tlb_lock, tlb_we, tlb_re, tlb_probe_req;
   logic [18:0] tlb_probe_vpn2;
   logic [7:0] tlb_probe_asid;
`ifdef TLB_PROBE_MULTIHIT_EN
   logic [7:0] tlb_probe_hit_vec;
   logic mcheck;
`else
   logic tlb_probe_hit;
   logic [2:0] tlb_probe_index;
`endif

   always #5 clk = ~clk;

   tlb_op_sequencer dut (
      .clk(clk), .rst(rst),
      .op_valid(op_valid), .op_code(op_code), .op_ready(op_ready), .op_done(op_done),
      .flush(flush), .cp0_index(cp0_index), .cp0_random(cp0_random),
      .cp0_tlb_conf_out(cp0_tlb_conf_out), .cp0_tlbp(cp0_tlbp), .cp0_tlbr(cp0_tlbr),
      .miss_probe(miss_probe), .matched_index_probe(matched_index_probe),
      .cp0_tlb_conf_in(cp0_tlb_conf_in), .lookup_busy(lookup_busy), .tlb_lock(tlb_lock),
      .tlb_we(tlb_we), .tlb_re(tlb_re), .tlb_addr(tlb_addr), .tlb_wdata(tlb_wdata),
      .tlb_rdata(tlb_rdata),
`ifdef TLB_PROBE_MULTIHIT_EN
      .tlb_probe_hit_vec(tlb_probe_hit_vec), .mcheck(mcheck),
`else
      .tlb_probe_hit(tlb_probe_hit), .tlb_probe_index(tlb_probe_index),
`endif
      .tlb_probe_req(tlb_probe_req), .tlb_probe_vpn2(tlb_probe_vpn2),
      .tlb_probe_asid(tlb_probe_asid)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // ---------------------------------------------------------------- reference model
   bit          m_active   = 1'b0;  // an op is between acceptance and retirement
   bit          m_ready_ok = 1'b0;  // a clock edge has passed since reset release
   int          m_issue    = -1;    // cycle of the array access, -1 while draining
   int          cyc        = 0;
   logic [1:0]  m_op       = '0;
   logic [2:0]  m_addr     = '0;
   logic [85:0] m_conf     = '0;
   logic        m_miss     = 1'b0;
   logic [2:0]  m_idx      = '0;
   logic [85:0] m_rd       = '0;
   logic        m_mc       = 1'b0;

   initial begin : compare
      bit   is_issue, is_wait, is_commit, exp_ready, accept, hit, multi;
      logic [2:0] hidx;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst) begin
            m_active = 1'b0; m_ready_ok = 1'b0; m_issue = -1;
            m_miss = 1'b0; m_idx = '0; m_rd = '0; m_mc = 1'b0;
            check("reset_ctrl", {op_ready, tlb_lock, tlb_we, tlb_re, tlb_probe_req,
                                 op_done, cp0_tlbp, cp0_tlbr}, '0);
            check("reset_results", {miss_probe, matched_index_probe, cp0_tlb_conf_in}, '0);
         end else begin
            is_issue  = m_active && (m_issue >= 0) && (cyc == m_issue);
            is_wait   = m_active && (m_issue >= 0) && (cyc == m_issue + 1);
            is_commit = m_active && (m_issue >= 0) && (cyc == m_issue + 2);
            exp_ready = m_ready_ok && !m_active && !flush;
            check("ctrl {ready,lock,we,re,probe,done,tlbp,tlbr}",
                  {op_ready, tlb_lock, tlb_we, tlb_re, tlb_probe_req, op_done, cp0_tlbp, cp0_tlbr},
                  {exp_ready, m_active,
                   is_issue && m_op[1], is_issue && (m_op == 2'b01), is_issue && (m_op == 2'b00),
                   is_commit, is_commit && (m_op == 2'b00), is_commit && (m_op == 2'b01)});
            check("results {miss,idx,conf_in}",
                  {miss_probe, matched_index_probe, cp0_tlb_conf_in}, {m_miss, m_idx, m_rd});
`ifdef TLB_PROBE_MULTIHIT_EN
            check("mcheck", mcheck, is_commit && m_mc);
`endif
            if (is_issue) begin
               check("issue_addr", tlb_addr, m_addr);
               if (m_op[1]) check("issue_wdata", tlb_wdata, m_conf);
               if (m_op == 2'b00) check("issue_probe_key", {tlb_probe_vpn2, tlb_probe_asid},
                                        {m_conf[85:67], m_conf[65:58]});
            end
            // advance the model across the coming edge
            accept = exp_ready && op_valid;
            if (m_active) begin
               if (m_issue < 0) begin
                  if (flush)             m_active = 1'b0;
                  else if (!lookup_busy) m_issue  = cyc + 1;
               end else if (is_wait) begin
`ifdef TLB_PROBE_MULTIHIT_EN
                  hit = |tlb_probe_hit_vec;
                  multi = $countones(tlb_probe_hit_vec) > 1;
                  hidx = '0;
                  for (int i = 0; i < 8; i++)
                     if (tlb_probe_hit_vec[i] && ((tlb_probe_hit_vec & ((8'd1 << i) - 8'd1)) == 8'd0))
                        hidx = 3'(i);
`else
                  hit = tlb_probe_hit;
                  multi = 1'b0;
                  hidx = tlb_probe_index;
`endif
                  if (m_op == 2'b00) begin
                     m_miss = !hit;
                     m_idx  = hit ? hidx : 3'd0;
                  end
                  if (m_op == 2'b01) m_rd = tlb_rdata;
                  m_mc = (m_op == 2'b00) && multi;
               end else if (is_commit) begin
                  m_active = 1'b0;
               end
            end
            if (accept) begin
               m_active = 1'b1;
               m_issue  = -1;
               m_op     = op_code;
               m_addr   = (op_code == 2'b11) ? cp0_random : cp0_index;
               m_conf   = cp0_tlb_conf_out;
            end
            m_ready_ok = 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------- stimulus helpers
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      op_valid = 1'b0; op_code = 2'b00; flush = 1'b0; lookup_busy = 1'b0;
      cp0_index = '0; cp0_random = '0; cp0_tlb_conf_out = '0; tlb_rdata = '0;
`ifdef TLB_PROBE_MULTIHIT_EN
      tlb_probe_hit_vec = '0;
`else
      tlb_probe_hit = 1'b0; tlb_probe_index = '0;
`endif
   endtask

   task automatic set_probe_hit(input logic [2:0] idx);
`ifdef TLB_PROBE_MULTIHIT_EN
      tlb_probe_hit_vec = 8'd1 << idx;
`else
      tlb_probe_hit = 1'b1; tlb_probe_index = idx;
`endif
   endtask

   // Present one op in the current cycle (cycle +0) and move to cycle +1.
   task automatic start_op(input logic [1:0] code, input logic [2:0] idx, input logic [2:0] rnd,
                           input logic [85:0] conf, input string name);
      op_valid = 1'b1; op_code = code; cp0_index = idx; cp0_random = rnd; cp0_tlb_conf_out = conf;
      at_neg();
      check({name, "_ready"}, op_ready, 1'b1);
      tick();
      op_valid = 1'b0; cp0_index = ~idx; cp0_tlb_conf_out = ~conf;
   endtask

   localparam logic [85:0] CONF_WI = 86'h3A5A5A5A5A5A5A5A5A5A5A;
   localparam logic [85:0] RDATA_R = 86'h1555555555555555555555;
   localparam logic [85:0] CONF_P  = {19'h12345, 1'b0, 8'h2A, 58'h0};

   // ---------------------------------------------------------------- directed + random
   initial begin : stim
      logic [95:0] r96;
      idle_inputs();
      tick(); tick();
      at_neg();
      check("in_reset_lock", tlb_lock, 1'b0);
      check("in_reset_ready", op_ready, 1'b0);
      tick();
      rst = 1'b1;
      tick();
      at_neg();
      check("ready_after_reset", op_ready, 1'b1);
      tick();

      // TLBWI to index 5
      start_op(2'b10, 3'd5, 3'd0, CONF_WI, "wi");
      at_neg(); check("wi_lock_p1", {tlb_lock, tlb_we}, 2'b10);
      tick(); at_neg();
      check("wi_we_p2", tlb_we, 1'b1);
      check("wi_addr_p2", tlb_addr, 3'd5);
      check("wi_wdata_p2", tlb_wdata, CONF_WI);
      tick(); at_neg(); check("wi_no_done_p3", op_done, 1'b0);
      tick(); at_neg();
      check("wi_done_p4", op_done, 1'b1);
      check("wi_no_strobe_p4", {cp0_tlbp, cp0_tlbr}, 2'b00);
      tick();

      // TLBP hitting entry 3
      set_probe_hit(3'd3);
      start_op(2'b00, 3'd1, 3'd0, CONF_P, "tlbp");
      tick(); at_neg();
      check("tlbp_req_p2", tlb_probe_req, 1'b1);
      check("tlbp_vpn2_p2", tlb_probe_vpn2, 19'h12345);
      check("tlbp_asid_p2", tlb_probe_asid, 8'h2A);
      tick(); tick(); at_neg();
      check("tlbp_strobe_p4", {op_done, cp0_tlbp, cp0_tlbr}, 3'b110);
      check("tlbp_miss_p4", miss_probe, 1'b0);
      check("tlbp_index_p4", matched_index_probe, 3'd3);
      tick();
      idle_inputs();

      // TLBR of entry 7
      tlb_rdata = RDATA_R;
      start_op(2'b01, 3'd7, 3'd0, '0, "tlbr");
      tick(); at_neg();
      check("tlbr_re_p2", {tlb_re, tlb_addr}, {1'b1, 3'd7});
      tick(); tick(); at_neg();
      check("tlbr_strobe_p4", {op_done, cp0_tlbp, cp0_tlbr}, 3'b101);
      check("tlbr_data_p4", cp0_tlb_conf_in, RDATA_R);
      tick();

      // TLBWR: cp0_random moves after acceptance
      start_op(2'b11, 3'd0, 3'd2, CONF_WI, "tlbwr");
      cp0_random = 3'd6;
      tick(); at_neg();
      check("tlbwr_addr_p2", {tlb_we, tlb_addr}, {1'b1, 3'd2});
      tick(); tick(); tick();

      // lookup_busy for three cycles after acceptance
      lookup_busy = 1'b1;
      start_op(2'b10, 3'd4, 3'd0, CONF_WI, "busy");
      for (int k = 1; k <= 3; k++) begin
         at_neg();
         check($sformatf("busy_lock_p%0d", k), {tlb_lock, tlb_we}, 2'b10);
         tick();
      end
      lookup_busy = 1'b0;
      at_neg(); check("busy_p4", {tlb_lock, tlb_we, op_done}, 3'b100);
      tick(); at_neg(); check("busy_we_p5", tlb_we, 1'b1);
      tick(); tick(); at_neg(); check("busy_done_p7", op_done, 1'b1);
      tick();

      // flush while draining
      start_op(2'b10, 3'd1, 3'd0, CONF_WI, "fdrain");
      flush = 1'b1;
      at_neg(); check("fdrain_p1", {op_ready, tlb_lock}, 2'b01);
      tick();
      flush = 1'b0;
      for (int k = 2; k <= 5; k++) begin
         at_neg();
         check($sformatf("fdrain_quiet_p%0d", k),
               {op_ready, tlb_lock, tlb_we, tlb_re, tlb_probe_req, op_done}, 6'b100000);
         tick();
      end

      // flush while waiting is ignored
      start_op(2'b10, 3'd2, 3'd0, CONF_WI, "fwait");
      tick(); tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      at_neg(); check("fwait_done_p4", op_done, 1'b1);
      tick();

      // reset in the middle of WAIT
      tlb_rdata = ~RDATA_R;
      start_op(2'b01, 3'd6, 3'd0, '0, "rwait");
      tick(); tick();
      rst = 1'b0;
      #1;
      check("rwait_async_ctrl", {op_ready, tlb_lock, tlb_re, op_done, cp0_tlbr}, 5'b0);
      check("rwait_async_data", cp0_tlb_conf_in, '0);
      tick();
      rst = 1'b1;
      tick(); at_neg();
      check("rwait_after_release", {op_ready, tlb_lock, op_done, cp0_tlbr}, 4'b1000);
      tick();

`ifdef TLB_PROBE_MULTIHIT_EN
      // multi-hit on entries 2 and 5
      tlb_probe_hit_vec = 8'b0010_0100;
      start_op(2'b00, 3'd0, 3'd0, CONF_P, "multi");
      tick(); tick(); tick(); at_neg();
      check("multi_mcheck_p4", {cp0_tlbp, mcheck, miss_probe}, 3'b110);
      check("multi_index_p4", matched_index_probe, 3'd2);
      tick();
`endif

      // randomized phase; the model checks every cycle
      for (int n = 0; n < 4000; n++) begin
         op_valid    = $urandom_range(0, 1) == 0;
         op_code     = 2'($urandom_range(0, 3));
         cp0_index   = 3'($urandom_range(0, 7));
         cp0_random  = 3'($urandom_range(0, 7));
         r96 = {$urandom(), $urandom(), $urandom()};
         cp0_tlb_conf_out = r96[85:0];
         r96 = {$urandom(), $urandom(), $urandom()};
         tlb_rdata   = r96[85:0];
         lookup_busy = $urandom_range(0, 3) == 0;
         flush       = $urandom_range(0, 9) == 0;
`ifdef TLB_PROBE_MULTIHIT_EN
         tlb_probe_hit_vec = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 255))
                                                          : 8'd1 << $urandom_range(0, 7);
`else
         tlb_probe_hit   = $urandom_range(0, 1) == 1;
         tlb_probe_index = 3'($urandom_range(0, 7));
`endif
         if (!rst) rst = 1'b1;
         else if ($urandom_range(0, 399) == 0) rst = 1'b0;
         tick();
      end

      rst = 1'b1;
      idle_inputs();
      tick(); tick(); tick(); tick(); tick();
      at_neg();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
